voice_arbiter: RTL and testbench

VOICE_ARBITER -- requirements
Module: voice_arbiter

---
 rtl/voice_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_voice_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_arbiter.sv
// ---------------------------------------------------------------------------
// voice_arbiter
//
// Arbitrates voice-prompt requests from four requesters onto one player.
// Each requester owns a one-deep pending slot; the FSM picks a winner in
// round-robin order, strobes it to the player, then holds the player busy
// for PLAY_CYCLES followed by a silent guard of GAP_CYCLES.
//
// Ports
//   clk_50M          in   system clock, everything on the rising edge
//   s_rst            in   synchronous active-high reset
//   req[3:0]         in   one-cycle request strobe per requester
//   req_code[15:0]   in   voice codes, req_code[4i+3:4i] for requester i
//   flush            in   one-cycle strobe, discards every pending request
//   select_voice     out  voice code presented to the player
//   select_voice_en  out  one-cycle start strobe to the player
//   grant[3:0]       out  one-hot, one-cycle, requester being started
//   drop[3:0]        out  one-cycle, requester i's pending code overwritten
//   busy             out  high whenever the FSM is not IDLE
//   fsm_state[1:0]   out  debug view of the FSM state (IDLE/ISSUE/PLAY/GAP)
//
// Handshake: the player side is a fire-and-forget strobe. select_voice_en
// is high for exactly one cycle with select_voice valid in that same cycle;
// the player has no ready and must accept it. The arbiter guarantees the
// next strobe is at least PLAY_CYCLES+GAP_CYCLES+2 cycles later.
// ---------------------------------------------------------------------------
module voice_arbiter #(
  parameter int unsigned PLAY_CYCLES = 150_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input  logic        clk_50M,
  input  logic        s_rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_code,
  input  logic        flush,
  output logic [3:0]  select_voice,
  output logic        select_voice_en,
  output logic [3:0]  grant,
  output logic [3:0]  drop,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // Terminal counts; a zero-length phase is treated as one cycle for PLAY
  // and as "skip the phase" for GAP.
  localparam logic [27:0] PLAY_LAST = (PLAY_CYCLES == 0) ? 28'd0 : 28'(PLAY_CYCLES - 1);
  localparam logic [27:0] GAP_LAST  = (GAP_CYCLES  == 0) ? 28'd0 : 28'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES != 0);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [27:0]      cnt_q;
  logic [1:0]       last_grant_q;
  logic [3:0]       slot_vld_q;
  logic [3:0][3:0]  slot_code_q;
  logic [3:0]       sel_voice_q;
  logic             sel_en_q;
  logic [3:0]       grant_q;
  logic [3:0]       drop_q;
  logic             busy_q;

  // --------------------------------------------------------------------------
  // Round-robin winner search, starting one past the last grant.
  // --------------------------------------------------------------------------
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] rr_cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    rr_cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant_q + 2'(k);
      if (!win_found && slot_vld_q[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  // The winner is picked and its slot cleared on the edge that enters ISSUE,
  // so the strobe, grant and code all appear together in the ISSUE cycle.
  logic       issue_now;
  logic [3:0] clr_vec;

  always_comb begin
    issue_now = (state_q == S_IDLE) && win_found;
    clr_vec   = issue_now ? (4'b0001 << win_idx) : 4'b0000;
  end

  // --------------------------------------------------------------------------
  // Pending-slot next state.
  // A new request beats a same-edge clear (the slot refills, no drop).
  // Flush beats everything, including a same-edge request.
  // --------------------------------------------------------------------------
  logic [3:0]      load_vec;
  logic [3:0]      slot_vld_d;
  logic [3:0][3:0] slot_code_d;
  logic [3:0]      drop_d;

  always_comb begin
    load_vec    = '0;
    slot_vld_d  = '0;
    slot_code_d = slot_code_q;
    drop_d      = '0;
    for (int i = 0; i < 4; i++) begin
      load_vec[i]   = req[i] && (req_code[4*i +: 4] != 4'd0) && !flush;
      slot_vld_d[i] = !flush && (load_vec[i] || (slot_vld_q[i] && !clr_vec[i]));
      if (load_vec[i]) begin
        slot_code_d[i] = req_code[4*i +: 4];
      end
      drop_d[i]     = load_vec[i] && slot_vld_q[i] && !clr_vec[i];
    end
  end

  // --------------------------------------------------------------------------
  // FSM, slots and registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50M) begin
    if (s_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
      slot_vld_q   <= '0;
      slot_code_q  <= '0;
      sel_voice_q  <= '0;
      sel_en_q     <= 1'b0;
      grant_q      <= '0;
      drop_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_code_q <= slot_code_d;
      drop_q      <= drop_d;

      // Strobes default low; only the IDLE->ISSUE transition raises them.
      sel_en_q <= 1'b0;
      grant_q  <= '0;

      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q      <= S_ISSUE;
            cnt_q        <= '0;
            sel_en_q     <= 1'b1;
            grant_q      <= 4'b0001 << win_idx;
            sel_voice_q  <= slot_code_q[win_idx];
            last_grant_q <= win_idx;
            busy_q       <= 1'b1;
          end
        end

        S_ISSUE: begin
          state_q <= S_PLAY;
          cnt_q   <= '0;
        end

        S_PLAY: begin
          if (cnt_q == PLAY_LAST) begin
            cnt_q       <= '0;
            sel_voice_q <= '0;
            if (HAS_GAP) begin
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 28'd1;
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 28'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign select_voice    = sel_voice_q;
  assign select_voice_en = sel_en_q;
  assign grant           = grant_q;
  assign drop            = drop_q;
  assign busy            = busy_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_voice_arbiter.sv
// ---------------------------------------------------------------------------
// tb_voice_arbiter
//
// Directed bench for voice_arbiter with PLAY_CYCLES=10, GAP_CYCLES=3.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, i.e. they show the registers updated by that edge.
// "Cycle t" is the window in which an input is held before its sampling edge.
// ---------------------------------------------------------------------------
module tb_voice_arbiter;

  localparam int PC = 10;
  localparam int GC = 3;

  // Clock / reset
  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic        s_rst;
  logic [3:0]  req;
  logic [15:0] req_code;
  logic        flush;
  logic [3:0]  select_voice;
  logic        select_voice_en;
  logic [3:0]  grant;
  logic [3:0]  drop;
  logic        busy;
  logic [1:0]  fsm_state;

  voice_arbiter #(
    .PLAY_CYCLES (PC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk_50M         (clk_50M),
    .s_rst           (s_rst),
    .req             (req),
    .req_code        (req_code),
    .flush           (flush),
    .select_voice    (select_voice),
    .select_voice_en (select_voice_en),
    .grant           (grant),
    .drop            (drop),
    .busy            (busy),
    .fsm_state       (fsm_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Driver tasks
  task automatic step();
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pulse_req(input logic [3:0] r, input logic [15:0] codes);
    req      = r;
    req_code = codes;
    step();
    req      = '0;
    req_code = '0;
  endtask

  task automatic wait_en(input int budget, output int waited);
    waited = 0;
    while (!select_voice_en && waited < budget) begin
      step();
      waited++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic watch(input int n, output int en_cnt, output int busy_cnt);
    en_cnt   = 0;
    busy_cnt = 0;
    repeat (n) begin
      step();
      if (select_voice_en || grant != 4'd0) en_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, en_cnt, busy_cnt, prev;
    logic [3:0] exp_g;

    s_rst = 1'b1; req = '0; req_code = '0; flush = 1'b0;
    step(); step();

    // ---------------- reset state ----------------
    check_vec("rst_sel",   32'(select_voice),    32'h0);
    check_vec("rst_en",    32'(select_voice_en), 32'h0);
    check_vec("rst_grant", 32'(grant),           32'h0);
    check_vec("rst_drop",  32'(drop),            32'h0);
    check_vec("rst_busy",  32'(busy),            32'h0);
    check_vec("rst_state", 32'(fsm_state),       32'h0);
    s_rst = 1'b0;

    // ---------------- single request ----------------
    pulse_req(4'b0001, 16'h0005);                  // now t+1
    check_vec("single_t1_en",   32'(select_voice_en), 32'h0);
    check_vec("single_t1_busy", 32'(busy),            32'h0);
    step();                                        // t+2
    check_vec("single_t2_en",    32'(select_voice_en), 32'h1);
    check_vec("single_t2_grant", 32'(grant),           32'h1);
    check_vec("single_t2_sel",   32'(select_voice),    32'h5);
    check_vec("single_t2_busy",  32'(busy),            32'h1);
    step();                                        // t+3
    check_vec("single_t3_en",    32'(select_voice_en), 32'h0);
    check_vec("single_t3_grant", 32'(grant),           32'h0);
    check_vec("single_t3_sel",   32'(select_voice),    32'h5);
    repeat (9) step();                             // t+12
    check_vec("single_t12_sel",  32'(select_voice),    32'h5);
    check_vec("single_t12_busy", 32'(busy),            32'h1);
    step();                                        // t+13
    check_vec("single_t13_sel",  32'(select_voice),    32'h0);
    check_vec("single_t13_busy", 32'(busy),            32'h1);
    repeat (2) step();                             // t+15
    check_vec("single_t15_busy", 32'(busy),            32'h1);
    step();                                        // t+16
    check_vec("single_t16_busy", 32'(busy),            32'h0);
    check_vec("single_t16_state",32'(fsm_state),       32'h0);

    // ---------------- round-robin after reset ----------------
    s_rst = 1'b1; step(); s_rst = 1'b0;
    pulse_req(4'b1111, 16'h4321);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_en(40, w);
      exp_g = 4'b0001 << k;
      check_vec("rr_en",    32'(select_voice_en), 32'h1);
      check_vec("rr_grant", 32'(grant),           32'(exp_g));
      check_vec("rr_sel",   32'(select_voice),    32'(k + 1));
      if (k == 0) check_vec("rr_first_latency", 32'(w), 32'd1);
      else        check_vec("rr_spacing", 32'(cyc - prev), 32'd15);
      prev = cyc;
      step();
    end
    wait_idle(40);
    check_vec("rr_idle", 32'(busy), 32'h0);

    // ---------------- overwrite while playing ----------------
    pulse_req(4'b0001, 16'h0001);
    wait_en(40, w);
    check_vec("ovw_g0", 32'(grant), 32'h1);
    repeat (2) step();
    pulse_req(4'b0100, 16'h0700);
    check_vec("ovw_first_nodrop", 32'(drop), 32'h0);
    step();
    pulse_req(4'b0100, 16'h0900);
    check_vec("ovw_drop", 32'(drop), 32'h4);
    step();
    check_vec("ovw_drop_oneshot", 32'(drop), 32'h0);
    wait_en(40, w);
    check_vec("ovw_g2_en",    32'(select_voice_en), 32'h1);
    check_vec("ovw_g2_grant", 32'(grant),           32'h4);
    check_vec("ovw_g2_sel",   32'(select_voice),    32'h9);
    step();
    wait_idle(40);
    watch(20, en_cnt, busy_cnt);
    check_vec("ovw_no_replay", 32'(en_cnt), 32'd0);

    // ---------------- zero code ----------------
    pulse_req(4'b0001, 16'h0000);
    watch(20, en_cnt, busy_cnt);
    check_vec("zero_no_en",   32'(en_cnt),   32'd0);
    check_vec("zero_no_busy", 32'(busy_cnt), 32'd0);

    // ---------------- flush with simultaneous request ----------------
    flush = 1'b1;
    pulse_req(4'b0001, 16'h0003);
    flush = 1'b0;
    watch(20, en_cnt, busy_cnt);
    check_vec("flush_same_edge", 32'(en_cnt), 32'd0);

    // ---------------- flush during PLAY ----------------
    pulse_req(4'b0001, 16'h0003);
    wait_en(40, w);
    check_vec("flush_g0_grant", 32'(grant),        32'h1);
    check_vec("flush_g0_sel",   32'(select_voice), 32'h3);
    step();
    pulse_req(4'b0010, 16'h0060);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    check_vec("flush_play_busy", 32'(busy), 32'h1);
    wait_idle(40);
    watch(20, en_cnt, busy_cnt);
    check_vec("flush_no_grant", 32'(en_cnt), 32'd0);

    // ---------------- collision with the clearing edge ----------------
    pulse_req(4'b0010, 16'h0030);                  // t+1: slot 1 being picked
    pulse_req(4'b0010, 16'h0080);                  // t+2: ISSUE of code 3
    check_vec("col_en",     32'(select_voice_en), 32'h1);
    check_vec("col_grant",  32'(grant),           32'h2);
    check_vec("col_sel",    32'(select_voice),    32'h3);
    check_vec("col_nodrop", 32'(drop),            32'h0);
    prev = cyc;
    step();
    wait_en(40, w);
    check_vec("col_regrant", 32'(grant),        32'h2);
    check_vec("col_resel",   32'(select_voice), 32'h8);
    check_vec("col_spacing", 32'(cyc - prev),   32'd15);
    step();
    wait_idle(40);

    // ---------------- reset mid-PLAY ----------------
    pulse_req(4'b0001, 16'h0005);
    wait_en(40, w);                                // ISSUE at g
    step();                                        // g+1, count 0
    pulse_req(4'b0100, 16'h0200);                  // g+2, count 1
    repeat (3) step();                             // g+5, count 4
    check_vec("rstp_in_play", 32'(fsm_state), 32'h2);
    s_rst = 1'b1; step(); s_rst = 1'b0;            // g+6
    check_vec("rstp_busy",  32'(busy),            32'h0);
    check_vec("rstp_sel",   32'(select_voice),    32'h0);
    check_vec("rstp_en",    32'(select_voice_en), 32'h0);
    check_vec("rstp_state", 32'(fsm_state),       32'h0);
    watch(20, en_cnt, busy_cnt);
    check_vec("rstp_pending_lost", 32'(en_cnt), 32'd0);
    pulse_req(4'b0001, 16'h000a);
    step();
    check_vec("rstp_new_en",    32'(select_voice_en), 32'h1);
    check_vec("rstp_new_grant", 32'(grant),           32'h1);
    check_vec("rstp_new_sel",   32'(select_voice),    32'ha);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
